// File: rtl/ram_frame_reader.sv
// ram_frame_reader: drains one frame of DEPTH signed samples from an upstream
// valid/ready source into a registered downstream valid/ready stage, and keeps
// the sum and peak magnitude of the last completed frame.
//   clk_i, rst_ni          : clock, async active-low reset
//   frame_start_i          : pulse, a full frame is available upstream
//   rd_data_i/valid/ready  : upstream sample handshake
//   sample_o/valid/ready   : downstream sample handshake (registered data)
//   frame_sum_o/peak_o     : stats of the last completed frame
//   frame_done_o           : single-cycle pulse when stats are updated
//   overrun_o, clear_i     : sticky frame_start-while-busy flag and its clear
//   busy_o                 : high whenever not idle
module ram_frame_reader #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               frame_start_i,
  input  logic signed [WIDTH-1:0]            rd_data_i,
  input  logic                               rd_valid_i,
  output logic                               rd_ready_o,
  output logic signed [WIDTH-1:0]            sample_o,
  output logic                               sample_valid_o,
  input  logic                               sample_ready_i,
  output logic signed [WIDTH+ADDR_WIDTH-1:0] frame_sum_o,
  output logic        [WIDTH-1:0]            frame_peak_o,
  output logic                               frame_done_o,
  output logic                               overrun_o,
  input  logic                               clear_i,
  output logic                               busy_o
);

  localparam int unsigned SUM_W = WIDTH + ADDR_WIDTH;
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [SUM_W-1:0] sum_q, sum_d;
  logic [WIDTH-1:0]        peak_q, peak_d;
  logic signed [WIDTH-1:0] sample_q, sample_d;
  logic                    valid_q, valid_d;
  logic signed [SUM_W-1:0] fsum_q, fsum_d;
  logic [WIDTH-1:0]        fpeak_q, fpeak_d;
  logic                    ovr_q, ovr_d;

  logic             up_acc;
  logic             dn_acc;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] mag;

  assign rd_ready_o = (state_q == DRAIN) && (!valid_q || sample_ready_i);
  assign up_acc     = rd_valid_i && rd_ready_o;
  assign dn_acc     = valid_q && sample_ready_i;

  // Magnitude in WIDTH unsigned bits; the most negative value maps to 2^(WIDTH-1).
  assign raw = rd_data_i;
  assign mag = raw[WIDTH-1] ? (~raw + WIDTH'(1)) : raw;

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sum_q    <= '0;
      peak_q   <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      fsum_q   <= '0;
      fpeak_q  <= '0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      peak_q   <= peak_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      fsum_q   <= fsum_d;
      fpeak_q  <= fpeak_d;
      ovr_q    <= ovr_d;
    end
  end

  // Next-state, handshake and statistics logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    peak_d   = peak_q;
    sample_d = sample_q;
    valid_d  = valid_q;
    fsum_d   = fsum_q;
    fpeak_d  = fpeak_q;
    ovr_d    = ovr_q;

    // Set wins over clear so a coincident overrun is never lost.
    if (frame_start_i && (state_q != IDLE)) begin
      ovr_d = 1'b1;
    end else if (clear_i) begin
      ovr_d = 1'b0;
    end

    if (up_acc) begin
      sample_d = rd_data_i;
      valid_d  = 1'b1;
      cnt_d    = cnt_q + CNT_W'(1);
      sum_d    = sum_q + SUM_W'(rd_data_i);
      if (mag > peak_q) peak_d = mag;
    end else if (dn_acc) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (frame_start_i) begin
          state_d = DRAIN;
          cnt_d   = '0;
          sum_d   = '0;
          peak_d  = '0;
        end
      end
      DRAIN: begin
        if (up_acc && (cnt_q == CNT_W'(DEPTH - 1))) state_d = FLUSH;
      end
      FLUSH: begin
        if (!valid_q || sample_ready_i) begin
          state_d = DONE;
          fsum_d  = sum_q;
          fpeak_d = peak_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sample_o       = sample_q;
  assign sample_valid_o = valid_q;
  assign frame_sum_o    = fsum_q;
  assign frame_peak_o   = fpeak_q;
  assign frame_done_o   = (state_q == DONE);
  assign overrun_o      = ovr_q;
  assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_ram_frame_reader.sv
// Directed bench for ram_frame_reader at WIDTH=8, DEPTH=4.
module tb_ram_frame_reader;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int AW = 2;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic                frame_start_i;
  logic signed [W-1:0] rd_data_i;
  logic                rd_valid_i;
  logic                rd_ready_o;
  logic signed [W-1:0] sample_o;
  logic                sample_valid_o;
  logic                sample_ready_i;
  logic signed [W+AW-1:0] frame_sum_o;
  logic [W-1:0]        frame_peak_o;
  logic                frame_done_o;
  logic                overrun_o;
  logic                clear_i;
  logic                busy_o;

  int n_chk = 0;
  int n_bad = 0;

  logic signed [W-1:0] src [D];
  logic signed [W-1:0] got [$];
  int ndone;

  ram_frame_reader #(.WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .frame_start_i(frame_start_i),
    .rd_data_i(rd_data_i), .rd_valid_i(rd_valid_i), .rd_ready_o(rd_ready_o),
    .sample_o(sample_o), .sample_valid_o(sample_valid_o),
    .sample_ready_i(sample_ready_i), .frame_sum_o(frame_sum_o),
    .frame_peak_o(frame_peak_o), .frame_done_o(frame_done_o),
    .overrun_o(overrun_o), .clear_i(clear_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_src(input int a, input int b, input int c, input int d);
    src[0] = W'(a); src[1] = W'(b); src[2] = W'(c); src[3] = W'(d);
  endtask

  // Runs one frame. vmode: 0 always valid, 1 valid on odd cycles.
  // rmode: 0 always ready, 1 stall cycles 1..5, 2 random ready.
  task automatic run_frame(input int vmode, input int rmode, input int ovr_cyc,
                           input int clr_cyc, output int nd);
    int up_idx;
    int extra;
    up_idx = 0;
    extra  = 0;
    nd     = 0;
    got.delete();
    @(posedge clk_i); #1;
    frame_start_i = 1'b1;
    @(posedge clk_i); #1;
    frame_start_i = 1'b0;
    for (int c = 0; c < 80; c++) begin
      rd_valid_i     = (vmode == 0) ? 1'b1 : ((c % 2) == 1);
      rd_data_i      = src[(up_idx < D) ? up_idx : 0];
      case (rmode)
        1:       sample_ready_i = !(c >= 1 && c <= 5);
        2:       sample_ready_i = 1'($urandom_range(0, 1));
        default: sample_ready_i = 1'b1;
      endcase
      frame_start_i = (c == ovr_cyc);
      clear_i       = (c == clr_cyc);
      @(negedge clk_i);
      if (rmode == 1 && c >= 1 && c <= 5) begin
        check("stall_hold_data", sample_o, 3);
        check("stall_rd_ready", rd_ready_o, 0);
      end
      if (rd_valid_i && rd_ready_o) up_idx++;
      if (sample_valid_o && sample_ready_i) got.push_back(sample_o);
      if (frame_done_o) nd++;
      @(posedge clk_i); #1;
      if (nd > 0) extra++;
      if (extra == 3) break;
    end
    rd_valid_i     = 1'b0;
    sample_ready_i = 1'b0;
    frame_start_i  = 1'b0;
    clear_i        = 1'b0;
  endtask

  task automatic check_frame(input int sum, input int peak, input int nd);
    longint obs;
    check("frame_done_pulses", nd, 1);
    check("sample_count", got.size(), D);
    for (int i = 0; i < D; i++) begin
      obs = (i < got.size()) ? longint'(got[i]) : 999;
      check("sample_order", obs, src[i]);
    end
    check("frame_sum", frame_sum_o, sum);
    check("frame_peak", frame_peak_o, peak);
    check("busy_after_done", busy_o, 0);
  endtask

  initial begin
    rst_ni = 1'b0; frame_start_i = 1'b0; rd_data_i = '0; rd_valid_i = 1'b0;
    sample_ready_i = 1'b0; clear_i = 1'b0;
    #12;
    check("rst_rd_ready", rd_ready_o, 0);
    check("rst_valid", sample_valid_o, 0);
    check("rst_done", frame_done_o, 0);
    check("rst_overrun", overrun_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_sample", sample_o, 0);
    check("rst_sum", frame_sum_o, 0);
    check("rst_peak", frame_peak_o, 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // Streaming frame, -128 must give peak 128.
    set_src(3, -5, 7, -128);
    run_frame(0, 0, -1, -1, ndone);
    check_frame(-123, 128, ndone);
    check("no_overrun", overrun_o, 0);

    // Downstream stall after the first sample.
    run_frame(0, 1, -1, -1, ndone);
    check_frame(-123, 128, ndone);

    // frame_start during DRAIN: flag sticks, frame completes.
    set_src(10, 20, -30, 5);
    run_frame(0, 0, 2, -1, ndone);
    check_frame(5, 30, ndone);
    check("overrun_set", overrun_o, 1);
    @(posedge clk_i); #1;
    check("overrun_sticky", overrun_o, 1);
    clear_i = 1'b1;
    @(posedge clk_i); #1;
    clear_i = 1'b0;
    check("overrun_cleared", overrun_o, 0);
    check("sum_holds", frame_sum_o, 5);

    // Coincident clear and overrun: set wins.
    set_src(1, 2, 3, 4);
    run_frame(0, 0, 1, 1, ndone);
    check_frame(10, 4, ndone);
    check("overrun_set_wins", overrun_o, 1);
    clear_i = 1'b1;
    @(posedge clk_i); #1;
    clear_i = 1'b0;
    check("overrun_cleared2", overrun_o, 0);

    // Reset after two accepted samples.
    @(posedge clk_i); #1;
    frame_start_i = 1'b1;
    @(posedge clk_i); #1;
    frame_start_i = 1'b0;
    rd_valid_i = 1'b1; sample_ready_i = 1'b1; rd_data_i = 8'sd50;
    @(posedge clk_i); #1;
    rd_data_i = 8'sd60;
    @(posedge clk_i); #2;
    check("pre_rst_busy", busy_o, 1);
    rst_ni = 1'b0;
    #1;
    check("arst_rd_ready", rd_ready_o, 0);
    check("arst_valid", sample_valid_o, 0);
    check("arst_busy", busy_o, 0);
    check("arst_done", frame_done_o, 0);
    check("arst_sample", sample_o, 0);
    check("arst_sum", frame_sum_o, 0);
    check("arst_peak", frame_peak_o, 0);
    rd_valid_i = 1'b0; sample_ready_i = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    set_src(1, 1, 1, 1);
    run_frame(0, 0, -1, -1, ndone);
    check_frame(4, 1, ndone);

    // Toggling valid with random downstream ready.
    set_src(-1, -2, -3, -4);
    run_frame(1, 2, -1, -1, ndone);
    check_frame(-10, 4, ndone);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
